// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - segment table, blanking constants and scan state encoding
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] ANODES_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry for hex digit i sits at SEG_TABLE[i]
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - hex nibble to active-low seven-segment cathode pattern
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_controller.sv
// rtl/seven_seg_scan_controller.sv - 8-digit multiplexed display scanner with frame-aligned loads
// Optional leading-zero suppression: SEVEN_SEG_LEADING_ZERO_BLANK_EN
module seven_seg_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        cmosClock,
    input  logic        resetN,
    input  logic        loadValid,
    output logic        loadReady,
    input  logic [31:0] loadWord,
    input  logic [7:0]  loadDp,
    input  logic [7:0]  loadBlank,
    output logic [7:0]  anodes,
    output logic [6:0]  cathodes,
    output logic        dp,
    output logic        frameStart
);

    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [31:0]      active_word;
    logic [7:0]       active_dp;
    logic [7:0]       active_blank;
    logic [31:0]      pending_word;
    logic [7:0]       pending_dp;
    logic [7:0]       pending_blank;
    logic             pending_full;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       digit_idx;
    scan_state_t      state;

    logic             slot_wrap;
    logic             frame_wrap;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_segments;
    logic [7:0]       dark_mask;
    logic [7:0]       anodes_next;

    assign slot_wrap  = (slot_cnt == CNT_LAST);
    assign frame_wrap = slot_wrap && (digit_idx == IDX_LAST);
    assign cnt_next   = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
    assign cur_nibble = active_word[{digit_idx, 2'b00} +: 4];
    assign loadReady  = ~pending_full;

    seven_seg_decoder u_decoder (
        .nibble   (cur_nibble),
        .segments (cur_segments)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] lz_mask;
    logic       lz_seen;

    // Walk from the most significant digit down; digit 0 is never suppressed
    always_comb begin
        lz_mask = '0;
        lz_seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (active_word[i*4 +: 4] != 4'h0) lz_seen = 1'b1;
            lz_mask[i] = ~lz_seen;
        end
    end

    assign dark_mask = active_blank | lz_mask;
`else
    assign dark_mask = active_blank;
`endif

    always_comb begin
        anodes_next = ANODES_OFF;
        if (state == ST_DRIVE && !dark_mask[digit_idx] && int'(digit_idx) < NUM_DIGITS)
            anodes_next[digit_idx] = 1'b0;
    end

    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            active_word   <= '0;
            active_dp     <= '0;
            active_blank  <= '0;
            pending_word  <= '0;
            pending_dp    <= '0;
            pending_blank <= '0;
            pending_full  <= 1'b0;
            slot_cnt      <= '0;
            digit_idx     <= '0;
            state         <= ST_BLANK;
            anodes        <= ANODES_OFF;
            cathodes      <= SEG_OFF;
            dp            <= 1'b1;
            frameStart    <= 1'b0;
        end else begin
            slot_cnt   <= cnt_next;
            state      <= (cnt_next < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
            frameStart <= frame_wrap;

            if (slot_wrap)
                digit_idx <= frame_wrap ? 3'd0 : digit_idx + 3'd1;

            // Swap only at the frame boundary so a frame never mixes two words
            if (frame_wrap && pending_full) begin
                active_word  <= pending_word;
                active_dp    <= pending_dp;
                active_blank <= pending_blank;
                pending_full <= 1'b0;
            end else if (loadValid && !pending_full) begin
                pending_word  <= loadWord;
                pending_dp    <= loadDp;
                pending_blank <= loadBlank;
                pending_full  <= 1'b1;
            end

            anodes <= anodes_next;
            if (state == ST_DRIVE) begin
                cathodes <= cur_segments;
                dp       <= ~active_dp[digit_idx];
            end else begin
                cathodes <= SEG_OFF;
                dp       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb/tb_seven_seg_scan_controller.sv - directed self-checking bench for seven_seg_scan_controller
module tb_seven_seg_scan_controller;

    logic        cmosClock = 1'b0;
    logic        resetN    = 1'b0;
    logic        loadValid = 1'b0;
    logic        loadReady;
    logic [31:0] loadWord  = '0;
    logic [7:0]  loadDp    = '0;
    logic [7:0]  loadBlank = '0;
    logic [7:0]  anodes;
    logic [6:0]  cathodes;
    logic        dp;
    logic        frameStart;

    int total = 0;
    int bad   = 0;
    int pos   = 0;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] D7_ANODES = 8'hFF;
`else
    localparam logic [7:0] D7_ANODES = 8'h7F;
`endif

    always #5 cmosClock = ~cmosClock;

    seven_seg_scan_controller #(
        .NUM_DIGITS   (8),
        .TICK_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .cmosClock  (cmosClock),
        .resetN     (resetN),
        .loadValid  (loadValid),
        .loadReady  (loadReady),
        .loadWord   (loadWord),
        .loadDp     (loadDp),
        .loadBlank  (loadBlank),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .dp         (dp),
        .frameStart (frameStart)
    );

    // pos = cycles since the frameStart sample; outputs at pos k show counter (k-1)%8 of digit (k-1)/8
    task automatic step_to(input int k);
        while (pos < k) begin
            @(posedge cmosClock);
            @(negedge cmosClock);
            pos++;
        end
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge cmosClock);
            @(negedge cmosClock);
            if (frameStart === 1'b1) begin
                ok  = 1'b1;
                pos = 0;
                break;
            end
        end
    endtask

    task automatic do_load(input logic [31:0] w, input logic [7:0] d, input logic [7:0] b,
                           output bit ok);
        loadWord  = w;
        loadDp    = d;
        loadBlank = b;
        loadValid = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (loadReady === 1'b1) ok = 1'b1;
            @(posedge cmosClock);
            @(negedge cmosClock);
            pos++;
            if (ok) break;
        end
        loadValid = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        resetN = 1'b0;
        repeat (3) @(negedge cmosClock);
        total++; if (anodes !== 8'hFF) begin bad++; $display("FAIL rst_anodes got=%h want=ff", anodes); end
        total++; if (cathodes !== 7'h7F) begin bad++; $display("FAIL rst_cathodes got=%h want=7f", cathodes); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b want=1", dp); end
        total++; if (loadReady !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", loadReady); end
        total++; if (frameStart !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b want=0", frameStart); end
        resetN = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge cmosClock);
            @(negedge cmosClock);
            n++;
            if (frameStart === 1'b1) break;
        end
        pos = 0;
        total++; if (n !== 64) begin bad++; $display("FAIL first_fs_delay got=%0d want=64", n); end
    endtask

    task automatic test_load_digits;
        bit ok;
        do_load(32'h0123_4567, 8'h00, 8'h00, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL load1_accept got=%b want=1", ok); end
        wait_frame(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL load1_frame got=%b want=1", ok); end
        step_to(3);
        total++; if (anodes !== 8'hFE) begin bad++; $display("FAIL d0_anodes got=%h want=fe", anodes); end
        total++; if (cathodes !== 7'h78) begin bad++; $display("FAIL d0_cathodes got=%h want=78", cathodes); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL d0_dp got=%b want=1", dp); end
        step_to(27);
        total++; if (anodes !== 8'hF7) begin bad++; $display("FAIL d3_anodes got=%h want=f7", anodes); end
        total++; if (cathodes !== 7'h19) begin bad++; $display("FAIL d3_cathodes got=%h want=19", cathodes); end
        step_to(59);
        total++; if (anodes !== D7_ANODES) begin bad++; $display("FAIL d7_anodes got=%h want=%h", anodes, D7_ANODES); end
        total++; if (cathodes !== 7'h40) begin bad++; $display("FAIL d7_cathodes got=%h want=40", cathodes); end
    endtask

    task automatic test_slot_timing;
        bit ok;
        logic [7:0] exp_an;
        wait_frame(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL slot_frame got=%b want=1", ok); end
        for (int k = 9; k <= 16; k++) begin
            step_to(k);
            exp_an = (k <= 10) ? 8'hFF : 8'hFD;
            total++; if (anodes !== exp_an) begin bad++; $display("FAIL slot_k%0d_anodes got=%h want=%h", k, anodes, exp_an); end
            total++; if (frameStart !== 1'b0) begin bad++; $display("FAIL slot_k%0d_fs got=%b want=0", k, frameStart); end
        end
        step_to(64);
        total++; if (frameStart !== 1'b1) begin bad++; $display("FAIL wrap_fs got=%b want=1", frameStart); end
        total++; if (anodes !== D7_ANODES) begin bad++; $display("FAIL wrap_d7_anodes got=%h want=%h", anodes, D7_ANODES); end
        step_to(65);
        total++; if (frameStart !== 1'b0) begin bad++; $display("FAIL wrap_fs_clear got=%b want=0", frameStart); end
        total++; if (anodes !== 8'hFF) begin bad++; $display("FAIL wrap_guard_anodes got=%h want=ff", anodes); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit got;
        logic fs;
        do_load(32'h1111_1111, 8'h00, 8'h00, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_first_accept got=%b want=1", ok); end
        total++; if (loadReady !== 1'b0) begin bad++; $display("FAIL b2b_ready_low got=%b want=0", loadReady); end
        loadWord  = 32'h2222_2222;
        loadDp    = 8'h00;
        loadBlank = 8'h00;
        loadValid = 1'b1;
        got = 1'b0;
        fs  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (loadReady === 1'b1) begin
                got = 1'b1;
                fs  = frameStart;
                break;
            end
            @(posedge cmosClock);
            @(negedge cmosClock);
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL b2b_second_ready got=%b want=1", got); end
        total++; if (fs !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_fs got=%b want=1", fs); end
        pos = 0;
        @(posedge cmosClock);
        @(negedge cmosClock);
        pos = 1;
        loadValid = 1'b0;
        total++; if (loadReady !== 1'b0) begin bad++; $display("FAIL b2b_second_pending got=%b want=0", loadReady); end
        step_to(3);
        total++; if (anodes !== 8'hFE) begin bad++; $display("FAIL b2b_a_d0_anodes got=%h want=fe", anodes); end
        total++; if (cathodes !== 7'h79) begin bad++; $display("FAIL b2b_a_d0_cathodes got=%h want=79", cathodes); end
        step_to(59);
        total++; if (anodes !== 8'h7F) begin bad++; $display("FAIL b2b_a_d7_anodes got=%h want=7f", anodes); end
        total++; if (cathodes !== 7'h79) begin bad++; $display("FAIL b2b_a_d7_cathodes got=%h want=79", cathodes); end
        wait_frame(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_frame2 got=%b want=1", ok); end
        step_to(3);
        total++; if (cathodes !== 7'h24) begin bad++; $display("FAIL b2b_b_d0_cathodes got=%h want=24", cathodes); end
        total++; if (loadReady !== 1'b1) begin bad++; $display("FAIL b2b_ready_restored got=%b want=1", loadReady); end
    endtask

    task automatic test_blank_dp;
        bit ok;
        do_load(32'h0000_00A5, 8'h01, 8'h04, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bd_accept got=%b want=1", ok); end
        wait_frame(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bd_frame got=%b want=1", ok); end
        step_to(3);
        total++; if (anodes !== 8'hFE) begin bad++; $display("FAIL bd_d0_anodes got=%h want=fe", anodes); end
        total++; if (cathodes !== 7'h12) begin bad++; $display("FAIL bd_d0_cathodes got=%h want=12", cathodes); end
        total++; if (dp !== 1'b0) begin bad++; $display("FAIL bd_d0_dp got=%b want=0", dp); end
        step_to(11);
        total++; if (anodes !== 8'hFD) begin bad++; $display("FAIL bd_d1_anodes got=%h want=fd", anodes); end
        total++; if (cathodes !== 7'h08) begin bad++; $display("FAIL bd_d1_cathodes got=%h want=08", cathodes); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL bd_d1_dp got=%b want=1", dp); end
        step_to(19);
        total++; if (anodes !== 8'hFF) begin bad++; $display("FAIL bd_d2_anodes got=%h want=ff", anodes); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        wait_frame(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rm_frame got=%b want=1", ok); end
        step_to(4);
        total++; if (anodes !== 8'hFE) begin bad++; $display("FAIL rm_drive_anodes got=%h want=fe", anodes); end
        do_load(32'h0000_0003, 8'hFF, 8'h00, ok);
        total++; if (loadReady !== 1'b0) begin bad++; $display("FAIL rm_pending_full got=%b want=0", loadReady); end
        resetN = 1'b0;
        #1;
        total++; if (anodes !== 8'hFF) begin bad++; $display("FAIL rm_anodes got=%h want=ff", anodes); end
        total++; if (cathodes !== 7'h7F) begin bad++; $display("FAIL rm_cathodes got=%h want=7f", cathodes); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL rm_dp got=%b want=1", dp); end
        total++; if (loadReady !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", loadReady); end
        total++; if (frameStart !== 1'b0) begin bad++; $display("FAIL rm_fs got=%b want=0", frameStart); end
        @(negedge cmosClock);
        resetN = 1'b1;
        wait_frame(ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL rm_frame_after got=%b want=1", ok); end
        step_to(3);
        total++; if (anodes !== 8'hFE) begin bad++; $display("FAIL rm_after_anodes got=%h want=fe", anodes); end
        total++; if (cathodes !== 7'h40) begin bad++; $display("FAIL rm_after_cathodes got=%h want=40", cathodes); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL rm_after_dp got=%b want=1", dp); end
    endtask

    initial begin
        test_reset();
        test_load_digits();
        test_slot_timing();
        test_back_to_back();
        test_blank_dp();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
